// File: rtl/dapuf_pkg.sv
// Shared types and helpers for the DAPUF evaluation controller.
// Holds the FSM state encoding, the default challenge width and the
// majority/stability rules applied to the count of sampled ones.
package dapuf_pkg;

  localparam int CHAL_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FIRE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Majority vote: more than half of the n evaluations sampled a one.
  function automatic logic maj_bit(input int ones, input int n);
    return (ones > (n / 2));
  endfunction

  // Stable when every evaluation produced the same value.
  function automatic logic all_agree(input int ones, input int n);
    return ((ones == 0) || (ones == n));
  endfunction

endpackage

// File: rtl/dapuf_sync2.sv
// Two-flop synchronizer for an asynchronous PUF output into the clk domain.
// Latency: 2 cycles from a stable input to q.
// Backpressure: none, free-running every cycle.
module dapuf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only the second stage is consumed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dapuf_ctrl.sv
// DAPUF initiator: takes a challenge, fires NUM_EVAL excite pulses, majority-votes the response.
// Latency: NUM_EVAL*(SETTLE_CYC+EVAL_CYC) cycles from accept edge to resp_valid.
// Backpressure: chal_ready only in IDLE; result held in DONE until resp_ready, excite kept low.
module dapuf_ctrl
  import dapuf_pkg::*;
#(
  parameter int CHAL_W     = CHAL_W_DEF,
  parameter int NUM_EVAL   = 15,
  parameter int SETTLE_CYC = 4,
  parameter int EVAL_CYC   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          chal_valid,
  output logic                          chal_ready,
  input  logic [CHAL_W-1:0]             chal_in,
  output logic [CHAL_W-1:0]             puf_challenge,
  output logic                          puf_exciteL,
  output logic                          puf_exciteR,
  input  logic                          puf_response,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_bit,
  output logic [$clog2(NUM_EVAL+1)-1:0] resp_ones,
  output logic                          resp_stable,
  output logic                          busy
);

  localparam int CNT_W   = $clog2(NUM_EVAL + 1);
  localparam int CYC_MAX = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  state_t           state_q, state_nxt;
  logic [CYC_W-1:0] cyc_q;
  logic [CNT_W-1:0] eval_q;
  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] ones_inc;
  logic             excite_q;
  logic             resp_s;
  logic             accept;
  logic             settle_end;
  logic             fire_end;
  logic             last_eval;

  dapuf_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (puf_response),
    .q   (resp_s)
  );

  // Reset holds chal_ready low even though the state register already reads IDLE.
  assign chal_ready  = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == DONE);
  assign puf_exciteL = excite_q;
  assign puf_exciteR = excite_q;
  assign ones_inc    = ones_q + CNT_W'(resp_s);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic and phase-boundary strobes.
  always_comb begin
    state_nxt  = state_q;
    accept     = 1'b0;
    settle_end = 1'b0;
    fire_end   = 1'b0;
    last_eval  = 1'b0;
    case (state_q)
      IDLE: begin
        if (chal_valid && chal_ready) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
          settle_end = 1'b1;
          state_nxt  = FIRE;
        end
      end
      FIRE: begin
        if (cyc_q == CYC_W'(EVAL_CYC - 1)) begin
          fire_end = 1'b1;
          if (eval_q == CNT_W'(NUM_EVAL - 1)) begin
            last_eval = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = SETTLE;
          end
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: challenge latch, phase/eval/ones counters, excite flop, result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      puf_challenge <= '0;
      excite_q      <= 1'b0;
      cyc_q         <= '0;
      eval_q        <= '0;
      ones_q        <= '0;
      resp_bit      <= 1'b0;
      resp_ones     <= '0;
      resp_stable   <= 1'b0;
    end else begin
      // Excite follows the upcoming state so it is high exactly in FIRE cycles.
      excite_q <= (state_nxt == FIRE);

      if (accept) begin
        puf_challenge <= chal_in;
        eval_q        <= '0;
        ones_q        <= '0;
      end

      if (accept || settle_end || fire_end) begin
        cyc_q <= '0;
      end else if ((state_q == SETTLE) || (state_q == FIRE)) begin
        cyc_q <= cyc_q + CYC_W'(1);
      end

      if (fire_end) begin
        ones_q <= ones_inc;
        eval_q <= eval_q + CNT_W'(1);
      end

      // Results latch once on DONE entry and persist after the handshake.
      if (last_eval) begin
        resp_ones   <= ones_inc;
        resp_bit    <= maj_bit(int'(ones_inc), NUM_EVAL);
        resp_stable <= all_agree(int'(ones_inc), NUM_EVAL);
      end
    end
  end

endmodule

// File: tb/tb_dapuf_ctrl.sv
// Self-checking bench for dapuf_ctrl with a per-challenge response pattern model.
// Each evaluation's response bit is applied when its excite pulse rises.
// Expected results come from popcount/majority arithmetic on the pattern.
module tb_dapuf_ctrl;

  localparam int CHAL_W     = 64;
  localparam int NUM_EVAL   = 15;
  localparam int SETTLE_CYC = 4;
  localparam int EVAL_CYC   = 8;
  localparam int CNT_W      = $clog2(NUM_EVAL + 1);
  localparam int LAT        = NUM_EVAL * (SETTLE_CYC + EVAL_CYC);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              chal_valid = 1'b0;
  logic              chal_ready;
  logic [CHAL_W-1:0] chal_in = '0;
  logic [CHAL_W-1:0] puf_challenge;
  logic              puf_exciteL;
  logic              puf_exciteR;
  logic              puf_response = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic              resp_bit;
  logic [CNT_W-1:0]  resp_ones;
  logic              resp_stable;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Shared with the excite monitor.
  logic [NUM_EVAL-1:0] pattern_v = '0;
  int                  pat_base  = 0;
  int                  rise_cnt  = 0;
  bit                  mon_en    = 1'b0;

  dapuf_ctrl #(
    .CHAL_W     (CHAL_W),
    .NUM_EVAL   (NUM_EVAL),
    .SETTLE_CYC (SETTLE_CYC),
    .EVAL_CYC   (EVAL_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .chal_valid    (chal_valid),
    .chal_ready    (chal_ready),
    .chal_in       (chal_in),
    .puf_challenge (puf_challenge),
    .puf_exciteL   (puf_exciteL),
    .puf_exciteR   (puf_exciteR),
    .puf_response  (puf_response),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_bit      (resp_bit),
    .resp_ones     (resp_ones),
    .resp_stable   (resp_stable),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Excite monitor: L/R equality, low-phase length, rise counting, response driving.
  int  low_len  = 100;
  bit  exc_prev = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      int idx;
      check("exc_lr", puf_exciteL, puf_exciteR);
      if (puf_exciteL && !exc_prev) begin
        check("settle_len", (low_len >= SETTLE_CYC), 1);
        idx = rise_cnt - pat_base;
        puf_response = (idx >= 0 && idx < NUM_EVAL) ? pattern_v[idx] : 1'b0;
        rise_cnt++;
      end
      low_len  = puf_exciteL ? 0 : low_len + 1;
      exc_prev = puf_exciteL;
    end
  end

  // One full challenge: accept, latency, result vs model, optional DONE stall.
  task automatic run_chal(input logic [CHAL_W-1:0] c, input logic [NUM_EVAL-1:0] pat,
                          input bit stall);
    int lat;
    int exp_ones;
    logic [CHAL_W-1:0] other;
    exp_ones  = $countones(pat);
    pattern_v = pat;
    pat_base  = rise_cnt;
    resp_ready = !stall;
    @(negedge clk);
    check("rdy_idle", chal_ready, 1);
    chal_in    = c;
    chal_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chal_valid = 1'b0;
    chal_in    = ~c;
    check("chal_latch", puf_challenge, c);
    check("busy_run", busy, 1);
    check("rdy_busy", chal_ready, 0);
    lat = 0;
    while (!resp_valid && lat < 3 * LAT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, LAT);
    check("chal_hold", puf_challenge, c);
    check("n_rises", rise_cnt - pat_base, NUM_EVAL);
    check("resp_ones", resp_ones, exp_ones);
    check("resp_bit", resp_bit, (exp_ones > NUM_EVAL / 2));
    check("resp_stable", resp_stable, (exp_ones == 0 || exp_ones == NUM_EVAL));
    if (stall) begin
      other      = {$urandom, $urandom};
      chal_in    = other;
      chal_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        check("stall_vld", resp_valid, 1);
        check("stall_ones", resp_ones, exp_ones);
        check("stall_exc", puf_exciteL, 0);
        check("stall_rdy", chal_ready, 0);
      end
      check("stall_chal", puf_challenge, c);
      chal_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("vld_drop", resp_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_rdy", chal_ready, 1);
    check("ones_keep", resp_ones, exp_ones);
  endtask

  initial begin
    int n;
    int pulses;
    logic [NUM_EVAL-1:0] rp;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", chal_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_vld", resp_valid, 0);
    check("rst_exc", puf_exciteL, 0);
    check("rst_chal", puf_challenge, 0);
    check("rst_ones", resp_ones, 0);
    check("rst_bit", resp_bit, 0);
    check("rst_stable", resp_stable, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", chal_ready, 1);

    // Directed patterns: all ones, 7 ones (below majority), 8 ones with DONE stall.
    run_chal(64'h05050F0F05050F0F, '1, 1'b0);
    run_chal({$urandom, $urandom}, 15'h007F, 1'b0);
    run_chal({$urandom, $urandom}, 15'h00FF, 1'b1);

    // Reset during the third FIRE phase.
    pattern_v = '1;
    pat_base  = rise_cnt;
    @(negedge clk);
    chal_in    = {$urandom, $urandom};
    chal_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chal_valid = 1'b0;
    n = 0;
    while ((rise_cnt - pat_base) < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_fire3", (rise_cnt - pat_base) >= 3, 1);
    @(negedge clk);
    check("fire3_exc", puf_exciteL, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_rdy", chal_ready, 0);
    rst = 1'b0;
    check("abort_exc", puf_exciteL, 0);
    check("abort_busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort_no_vld", pulses, 0);

    // Full result after the abort, then randomized patterns including all-zero.
    run_chal({$urandom, $urandom}, NUM_EVAL'($urandom), 1'b0);
    run_chal({$urandom, $urandom}, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rp = NUM_EVAL'($urandom);
      run_chal({$urandom, $urandom}, rp, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dapuf_ctrl.md
Name: dapuf_ctrl

Overview:
- Initiator side of the DAPUF evaluation interface.
- Accepts a challenge over a valid/ready handshake and drives the challenge bus to the PUF core.
- Sequences the excite pulses and samples the asynchronous response NUM_EVAL times, then returns a majority-voted response bit with a ones count and a stability flag.
- Sits between the host/test register file and the DAPUF core.

Parameters:
- CHAL_W, 64: challenge width. Matches the DAPUF selector chain length.
- NUM_EVAL, 15: evaluations per challenge. Must be odd and ≥1.
- SETTLE_CYC, 4: cycles with excite held low before each fire. Must be ≥1.
- EVAL_CYC, 8: cycles with excite held high before sampling. Must be ≥3.
- CNT_W, $clog2(NUM_EVAL+1): localparam, width of the ones counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- chal_valid  in  1  host challenge valid.
- chal_ready  out  1  controller can accept a challenge.
- chal_in  in  CHAL_W  host challenge.
- puf_challenge  out  CHAL_W  challenge to the PUF core; registered and held stable for the whole evaluation.
- puf_exciteL  out  1  left excite; registered.
- puf_exciteR  out  1  right excite; registered, always equal to puf_exciteL.
- puf_response  in  1  raw PUF response; asynchronous.
- resp_valid  out  1  result valid.
- resp_ready  in  1  host accepts the result.
- resp_bit  out  1  majority response.
- resp_ones  out  CNT_W  number of evaluations that sampled 1.
- resp_stable  out  1  all evaluations agreed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: chal_ready=0 during rst and 1 in the first IDLE cycle after it. puf_challenge=0, excite=0, resp_valid=0, resp_bit=0, resp_ones=0, resp_stable=0, busy=0. Sync flops=0, FSM=IDLE.
- puf_response goes through a 2-flop synchronizer. Only the second-stage value (resp_s) is used.
- FSM states: IDLE, SETTLE, FIRE, DONE.
- IDLE:
  - chal_ready=1.
  - On chal_valid&chal_ready: latch chal_in into puf_challenge, clear eval counter and ones counter, go to SETTLE.
- SETTLE:
  - Excite=0 for SETTLE_CYC cycles (cycle counter counts 0..SETTLE_CYC-1).
  - Then go to FIRE.
- FIRE:
  - Excite=1 for EVAL_CYC cycles.
  - On the last FIRE cycle, sample resp_s: ones += resp_s, eval counter += 1.
  - If eval counter reaches NUM_EVAL, go to DONE with excite=0. Otherwise go to SETTLE.
  - puf_exciteL and puf_exciteR rise and fall in the same clock edge. Neither is ever high in SETTLE, IDLE or DONE.
- DONE:
  - resp_valid=1.
  - resp_bit = (ones > NUM_EVAL/2).
  - resp_ones = ones.
  - resp_stable = (ones==0 || ones==NUM_EVAL).
  - Outputs hold until resp_valid&resp_ready, then return to IDLE.
  - resp_* register values persist after the handshake; only resp_valid drops.
- Latency: accept edge to resp_valid = NUM_EVAL*(SETTLE_CYC+EVAL_CYC) cycles. This is 180 with the defaults.
- Challenge handling: chal_ready=0 outside IDLE; chal_valid is ignored there. puf_challenge changes only on the accept edge.
- Back-to-back operation:
  - DONE→IDLE costs one cycle.
  - Minimum challenge-to-challenge period is latency + 2 cycles, assuming resp_ready is already high and chal_valid arrives in the IDLE cycle.
- resp_ready low in DONE: stall indefinitely, excite stays 0.
- rst asserted mid-operation: next edge forces reset values. Excite drops immediately and no partial result is emitted.
- Counter widths: the ones counter never exceeds NUM_EVAL and cannot wrap. The eval counter has CNT_W bits.

Decomposition:
- Package dapuf_pkg holds:
  - the state enum (IDLE/SETTLE/FIRE/DONE);
  - default CHAL_W=64;
  - a helper function for majority and stable computation.
- One sub-module, dapuf_sync2: a 2-flop synchronizer with synchronous reset, reused for any asynchronous PUF output.

Test Plan:
- Reset, then accept challenge 64'h05050F0F05050F0F with puf_response tied 1:
  - puf_challenge equals the challenge on the edge after accept;
  - resp_valid rises exactly 180 cycles after accept;
  - resp_bit=1, resp_ones=15, resp_stable=1.
- Model puf_response as 1 for the first 7 evaluations and 0 after (applied ≥3 cycles before each sample) → resp_ones=7, resp_bit=0, resp_stable=0.
- Model 8 ones, 7 zeros → resp_ones=8, resp_bit=1 (majority boundary), resp_stable=0.
- Hold resp_ready=0 for 50 cycles in DONE:
  - outputs stay stable, excite=0, chal_ready=0, and a new chal_valid is ignored;
  - after resp_ready=1, the FSM returns to IDLE in 1 cycle and the next challenge is accepted.
- Assert rst for 1 cycle during the 3rd FIRE phase:
  - excite=0 and busy=0 on the next edge;
  - no resp_valid pulse appears;
  - the next challenge produces a full 15-evaluation result.
- Assertion coverage across all runs:
  - puf_exciteL==puf_exciteR every cycle;
  - the number of excite rising edges per challenge is exactly NUM_EVAL;
  - every excite low phase lasts ≥SETTLE_CYC cycles.
